// File: rtl/cache_way_sched.sv
// Scheduler that turns one cache lookup result into a stable one-hot way select for the 4-way click selector.
// Tree-PLRU victim choice on a miss. Optional WAIT_FIRE timeout: define CACHE_SCHED_TIMEOUT_EN.
`timescale 1ns/1ps

module cache_way_sched #(
  parameter int SETS    = 16,
  parameter int IDX_W   = 4,
  parameter int DRIVE_W = 2
`ifdef CACHE_SCHED_TIMEOUT_EN
  , parameter int TO_CYC = 64
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [IDX_W-1:0] req_idx,
  input  logic             req_hit,
  input  logic [1:0]       req_way,
  output logic             sel_drive,
  output logic [3:0]       sel_valid,
  input  logic             sel_fire,
  output logic             done_valid,
  output logic [1:0]       done_way,
  output logic             done_miss,
  output logic             busy
`ifdef CACHE_SCHED_TIMEOUT_EN
  , output logic           to_err
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_WAIT, S_UPDATE} state_t;

  localparam int               DRV_CW   = (DRIVE_W > 1) ? $clog2(DRIVE_W) : 1;
  localparam logic [DRV_CW-1:0] DRV_LAST = DRV_CW'(DRIVE_W - 1);
  localparam logic [IDX_W:0]    SETS_W   = (IDX_W + 1)'(SETS);

  function automatic logic [1:0] plru_victim(input logic [2:0] b);
    return b[0] ? (b[2] ? 2'd3 : 2'd2) : (b[1] ? 2'd1 : 2'd0);
  endfunction

  // Point the tree away from the accessed way; the other half's bit is untouched.
  function automatic logic [2:0] plru_touch(input logic [2:0] b, input logic [1:0] w);
    logic [2:0] n;
    n    = b;
    n[0] = ~w[1];
    if (!w[1]) n[1] = ~w[0];
    else       n[2] = ~w[0];
    return n;
  endfunction

  state_t             r_state, w_next;
  logic [DRV_CW-1:0]  r_drv_cnt;
  logic               r_fire_s1, r_fire_s2, r_fire_s3;
  logic               w_fire_p;
  logic [2:0]         r_plru [SETS];
  logic [IDX_W-1:0]   r_set, w_set;
  logic               r_hit;
  logic [1:0]         r_way, w_target, w_way_sel;
  logic               r_sel_drive, w_sel_drive_d;
  logic [3:0]         r_sel_valid, w_sel_valid_d;
  logic               r_done_valid, w_done_valid_d;
  logic [1:0]         r_done_way, w_done_way_d;
  logic               r_done_miss, w_done_miss_d;

  // Indices past SETS alias back into the array when SETS is not a power of two.
  assign w_set    = ({1'b0, req_idx} < SETS_W) ? req_idx : IDX_W'({1'b0, req_idx} - SETS_W);
  assign w_target = req_hit ? req_way : plru_victim(r_plru[w_set]);
  assign w_fire_p = r_fire_s2 & ~r_fire_s3;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fire_s1 <= 1'b0;
      r_fire_s2 <= 1'b0;
      r_fire_s3 <= 1'b0;
    end else begin
      r_fire_s1 <= sel_fire;
      r_fire_s2 <= r_fire_s1;
      r_fire_s3 <= r_fire_s2;
    end
  end

`ifdef CACHE_SCHED_TIMEOUT_EN
  localparam int              TO_CW   = (TO_CYC > 2) ? $clog2(TO_CYC) : 1;
  localparam logic [TO_CW-1:0] TO_LAST = TO_CW'(TO_CYC - 1);
  logic [TO_CW-1:0] r_to_cnt;
  logic             r_to_err;
  logic             w_to_hit;

  assign w_to_hit = (r_state == S_WAIT) && !w_fire_p && (r_to_cnt == TO_LAST);
  assign to_err   = r_to_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_to_cnt <= '0;
      r_to_err <= 1'b0;
    end else begin
      r_to_cnt <= (r_state == S_WAIT) ? r_to_cnt + 1'b1 : '0;
      if (w_to_hit) r_to_err <= 1'b1;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_drv_cnt <= '0;
    end else begin
      r_state   <= w_next;
      r_drv_cnt <= (r_state == S_DRIVE) ? r_drv_cnt + 1'b1 : '0;
    end
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (req_valid) w_next = S_DRIVE;
      S_DRIVE:  if (r_drv_cnt == DRV_LAST) w_next = S_WAIT;
      S_WAIT: begin
        if (w_fire_p) w_next = S_UPDATE;
`ifdef CACHE_SCHED_TIMEOUT_EN
        else if (w_to_hit) w_next = S_IDLE;
`endif
      end
      S_UPDATE: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered, so they change only on clock edges.
  always_comb begin
    w_way_sel      = (r_state == S_IDLE) ? w_target : r_way;
    w_sel_drive_d  = (w_next == S_DRIVE);
    w_sel_valid_d  = ((w_next == S_DRIVE) || (w_next == S_WAIT)) ? (4'b0001 << w_way_sel) : 4'b0000;
    w_done_valid_d = (w_next == S_UPDATE);
    w_done_way_d   = (w_next == S_UPDATE) ? r_way : 2'd0;
    w_done_miss_d  = (w_next == S_UPDATE) && !r_hit;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sel_drive  <= 1'b0;
      r_sel_valid  <= 4'b0000;
      r_done_valid <= 1'b0;
      r_done_way   <= 2'd0;
      r_done_miss  <= 1'b0;
    end else begin
      r_sel_drive  <= w_sel_drive_d;
      r_sel_valid  <= w_sel_valid_d;
      r_done_valid <= w_done_valid_d;
      r_done_way   <= w_done_way_d;
      r_done_miss  <= w_done_miss_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_set <= '0;
      r_hit <= 1'b0;
      r_way <= 2'd0;
    end else if ((r_state == S_IDLE) && req_valid) begin
      r_set <= w_set;
      r_hit <= req_hit;
      r_way <= w_target;
    end
  end

  // NOTE: the PLRU array is reset as flops because a reset must leave every set choosing way 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < SETS; i++) r_plru[i] <= 3'b000;
    end else if (r_state == S_UPDATE) begin
      r_plru[r_set] <= plru_touch(r_plru[r_set], r_way);
    end
  end

  assign sel_drive  = r_sel_drive;
  assign sel_valid  = r_sel_valid;
  assign done_valid = r_done_valid;
  assign done_way   = r_done_way;
  assign done_miss  = r_done_miss;
  assign busy       = (r_state != S_IDLE);
  assign req_ready  = (r_state == S_IDLE);

endmodule

// File: tb/tb_cache_way_sched.sv
// Directed bench for cache_way_sched: a scoreboard queue of expected completions checked by a done_valid monitor.
`timescale 1ns/1ps

module tb_cache_way_sched;
  localparam int IDX_W   = 4;
  localparam int DRIVE_W = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [IDX_W-1:0] req_idx = '0;
  logic             req_hit = 1'b0;
  logic [1:0]       req_way = 2'd0;
  logic             sel_drive;
  logic [3:0]       sel_valid;
  logic             sel_fire = 1'b0;
  logic             done_valid;
  logic [1:0]       done_way;
  logic             done_miss;
  logic             busy;
`ifdef CACHE_SCHED_TIMEOUT_EN
  logic             to_err;
`endif

  always #5 clk = ~clk;

  cache_way_sched #(.SETS(16), .IDX_W(IDX_W), .DRIVE_W(DRIVE_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_idx    (req_idx),
    .req_hit    (req_hit),
    .req_way    (req_way),
    .sel_drive  (sel_drive),
    .sel_valid  (sel_valid),
    .sel_fire   (sel_fire),
    .done_valid (done_valid),
    .done_way   (done_way),
    .done_miss  (done_miss),
    .busy       (busy)
`ifdef CACHE_SCHED_TIMEOUT_EN
    , .to_err   (to_err)
`endif
  );

  typedef struct packed {
    logic [1:0] way;
    logic       miss;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_done   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitor: every completion pops the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst && done_valid) begin
      n_done++;
      check("done_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("done_way", done_way, e.way);
        check("done_miss", done_miss, e.miss);
      end
    end
  end

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_ready_wait"}, req_ready, 1);
  endtask

  // One transaction; fire is raised fire_dly cycles after the last sel_drive cycle and held 3 cycles.
  task automatic run_txn(input logic [3:0] idx, input logic hit, input logic [1:0] way,
                         input logic [1:0] exp_way, input int fire_dly, input bit toggle,
                         input string tag);
    int drv = 0, fire_left = 0, done_c = -1, fire_c = -1, fire_at;
    bit stable = 1'b1, rdy_low = 1'b1, got_done = 1'b0;
    logic [3:0] onehot;
    onehot = 4'b0001 << exp_way;
    wait_ready(tag);
    req_valid = 1'b1;
    req_idx   = idx;
    req_hit   = hit;
    req_way   = way;
    exp_q.push_back('{way: exp_way, miss: ~hit});
    fire_at = DRIVE_W + fire_dly;
    for (int c = 1; c <= fire_at + 20 && !got_done; c++) begin
      @(negedge clk);
      if (done_valid) begin
        got_done = 1'b1;
        done_c   = c;
      end else begin
        if (sel_drive) drv++;
        if (sel_valid !== onehot) stable = 1'b0;
        if (req_ready !== 1'b0) rdy_low = 1'b0;
      end
      if (fire_left > 0) begin
        fire_left--;
        if (fire_left == 0) sel_fire = 1'b0;
      end
      req_valid = (toggle && c < fire_at) ? c[0] : 1'b0;
      if (c == fire_at) begin
        sel_fire  = 1'b1;
        fire_left = 3;
        fire_c    = c;
      end
    end
    sel_fire = 1'b0;
    check({tag, "_done_seen"}, got_done, 1);
    check({tag, "_drive_cycles"}, drv, DRIVE_W);
    check({tag, "_sel_valid_stable"}, stable, 1);
    check({tag, "_ready_low"}, rdy_low, 1);
    check({tag, "_fire_to_done"}, done_c - fire_c, 3);
    @(negedge clk);
    check({tag, "_ready_after"}, req_ready, 1);
    check({tag, "_sel_valid_clear"}, sel_valid, 4'b0000);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_sel_drive"}, sel_drive, 0);
    check({tag, "_sel_valid"}, sel_valid, 4'b0000);
    check({tag, "_done_valid"}, done_valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_req_ready"}, req_ready, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int done_before;

    // T1: reset values, then four misses on set 0 walk the PLRU tree.
    repeat (3) @(negedge clk);
    check_reset_outputs("t1_in_reset");
`ifdef CACHE_SCHED_TIMEOUT_EN
    check("t1_to_err", to_err, 0);
`endif
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("t1_after_reset");
    run_txn(4'd0, 1'b0, 2'd3, 2'd0, 2, 1'b0, "t1_m0");
    run_txn(4'd0, 1'b0, 2'd1, 2'd2, 2, 1'b0, "t1_m1");
    run_txn(4'd0, 1'b0, 2'd0, 2'd1, 2, 1'b0, "t1_m2");
    run_txn(4'd0, 1'b0, 2'd2, 2'd3, 2, 1'b0, "t1_m3");

    // T2: hit on set 5 way 2, then the next victim there is way 0.
    run_txn(4'd5, 1'b1, 2'd2, 2'd2, 10, 1'b0, "t2_hit");
    run_txn(4'd5, 1'b0, 2'd3, 2'd0, 3, 1'b0, "t2_victim");

    // T3: long fire delay with req_valid toggling throughout.
    run_txn(4'd7, 1'b0, 2'd1, 2'd0, 30, 1'b1, "t3");

    // T4: spurious fire in IDLE produces nothing; the next request completes normally.
    done_before = n_done;
    sel_fire = 1'b1;
    repeat (3) @(negedge clk);
    sel_fire = 1'b0;
    repeat (6) @(negedge clk);
    check("t4_no_spurious_done", n_done, done_before);
    check("t4_idle_busy", busy, 0);
    run_txn(4'd0, 1'b0, 2'd1, 2'd0, 4, 1'b0, "t4");

    // Top index: hit way 1, then the victim comes from the right half.
    run_txn(4'd15, 1'b1, 2'd1, 2'd1, 1, 1'b0, "tb_hit15");
    run_txn(4'd15, 1'b0, 2'd0, 2'd2, 1, 1'b0, "tb_miss15");

    // T5: async reset while waiting for fire aborts the transaction and clears PLRU.
    wait_ready("t5");
    req_valid = 1'b1;
    req_idx   = 4'd0;
    req_hit   = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (DRIVE_W + 2) @(negedge clk);
    check("t5_in_wait_busy", busy, 1);
    check("t5_in_wait_sel_valid", sel_valid, 4'b0100);
    done_before = n_done;
    #1 rst = 1'b0;
    #1 check_reset_outputs("t5_async");
    @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    check("t5_no_done", n_done, done_before);
    run_txn(4'd0, 1'b0, 2'd3, 2'd0, 2, 1'b0, "t5_victim");

`ifdef CACHE_SCHED_TIMEOUT_EN
    // T6: no fire; to_err rises after 64 WAIT_FIRE cycles and set 3 keeps its PLRU state.
    begin
      int seen_c = -1;
      wait_ready("t6");
      req_valid = 1'b1;
      req_idx   = 4'd3;
      req_hit   = 1'b0;
      for (int c = 1; c <= 200 && seen_c < 0; c++) begin
        @(negedge clk);
        req_valid = 1'b0;
        if (to_err) seen_c = c;
      end
      check("t6_to_err_cycle", seen_c, DRIVE_W + 1 + 64);
      check("t6_ready", req_ready, 1);
      check("t6_sel_valid", sel_valid, 4'b0000);
      check("t6_no_done", done_valid, 0);
      run_txn(4'd3, 1'b0, 2'd2, 2'd0, 2, 1'b0, "t6_victim");
      check("t6_to_err_sticky", to_err, 1);
    end
`endif

    repeat (3) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
